// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data widths, reset PC, NOP encoding,
// PC step and the {addr, inst} entry held in the fetch buffer.
package riscv_pkg;

   localparam int XLEN   = 32;
   localparam int INST_W = 32;

   localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [INST_W-1:0] NOP              = 32'h0000_0013;
   localparam logic [XLEN-1:0]   PC_INC           = 32'd4;

   // One buffered instruction together with the PC it was fetched from.
   typedef struct packed {
      logic [XLEN-1:0]   addr;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

   // Force an address onto a word boundary.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
      return a & ~(XLEN'(3));
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect input and
// the decode-facing output channel. The master modport is the fetch unit's
// view, the slave modport the surrounding memory/decode/execute view.
// Optional: FETCH_MISALIGN_TRAP_EN adds the misalign_fault signal.
interface fetch_unit_if;
   import riscv_pkg::*;

   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [XLEN-1:0]   imem_req_addr;
   logic              imem_resp_valid;
   logic [INST_W-1:0] imem_resp_data;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_target;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_addr;
   logic [INST_W-1:0] out_inst;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic              misalign_fault;
`endif

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  redirect_valid, redirect_target,
      output out_valid, out_addr, out_inst,
      input  out_ready
`ifdef FETCH_MISALIGN_TRAP_EN
      , output misalign_fault
`endif
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output redirect_valid, redirect_target,
      input  out_valid, out_addr, out_inst,
      output out_ready
`ifdef FETCH_MISALIGN_TRAP_EN
      , input misalign_fault
`endif
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push, pop, flush and an occupancy count.
// Pop on an empty FIFO is ignored; flush wins over push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic             full, empty, do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Entry storage.
   // NOTE: the storage array has no reset; the pointers and count alone decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers and occupancy.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // The issue credit rule guarantees space; a push into a full FIFO is a design error.
   fifo_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction
// memory, pairs in-order responses with their PCs and buffers them for decode.
// Redirects flush everything and discard responses still in flight.
// Optional: FETCH_MISALIGN_TRAP_EN makes a redirect with target[1]=1 raise a
// sticky misalign_fault that halts fetch until rst.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int              FIFO_DEPTH = 2
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = $bits(fetch_entry_t);

   logic [XLEN-1:0] pc;
   logic [CW-1:0]   outstanding, outstanding_next, kill;
   logic [CW-1:0]   buf_count, aq_count;
   logic [CW:0]     in_use;
   logic [XLEN-1:0] aq_head;
   logic [EW-1:0]   buf_push, buf_head;
   fetch_entry_t    head_entry;
   logic            redirect, halted, credit_ok, req_valid, req_fire;
   logic            resp_fire, drop, resp_keep, out_valid, out_pop;

   assign redirect  = bus.redirect_valid;
   assign resp_fire = bus.imem_resp_valid;
   assign drop      = (kill != '0);
   assign resp_keep = resp_fire && !drop && (aq_count != '0);

   // Requests in flight plus words buffered may never exceed the buffer depth.
   assign in_use    = {1'b0, outstanding} + {1'b0, buf_count};
   assign credit_ok = in_use < (CW+1)'(FIFO_DEPTH);

   assign req_valid = !rst && !redirect && !halted && credit_ok;
   assign req_fire  = req_valid && bus.imem_req_ready;

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc;

   // Requests still awaiting a response once this cycle's handshakes complete.
   // NOTE: combinational blocks assign every output on every path, so no latch is inferred.
   always_comb begin
      outstanding_next = outstanding + CW'(req_fire) - CW'(resp_fire);
   end

   // PC advance on request handshake, reload on redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           pc <= RESET_PC;
      else if (redirect) pc <= align_word(bus.redirect_target);
      else if (req_fire) pc <= pc + PC_INC;
   end

   // Outstanding-request count and the number of stale responses to discard.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
         kill        <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (redirect)               kill <= outstanding_next;
         else if (resp_fire && drop) kill <= kill - CW'(1);
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault;

   // Sticky fault on a redirect to a non-word-aligned target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      fault <= 1'b0;
      else if (redirect && bus.redirect_target[1]) fault <= 1'b1;
   end

   assign halted             = fault;
   assign bus.misalign_fault = fault;
`else
   assign halted = 1'b0;
`endif

   // Issued PCs, popped in step with kept responses.
   fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_addr_q (
      .clk       (clk),
      .rst       (rst),
      .push      (req_fire),
      .push_data (pc),
      .pop       (resp_keep),
      .flush     (redirect),
      .head      (aq_head),
      .count     (aq_count)
   );

   assign buf_push = {aq_head, bus.imem_resp_data};

   // Instruction buffer presented to decode.
   fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_inst_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (resp_keep),
      .push_data (buf_push),
      .pop       (out_pop),
      .flush     (redirect),
      .head      (buf_head),
      .count     (buf_count)
   );

   assign head_entry = buf_head;
   assign out_valid  = (buf_count != '0);
   assign out_pop    = out_valid && bus.out_ready && !redirect;

   assign bus.out_valid = out_valid;
   assign bus.out_addr  = out_valid ? head_entry.addr : '0;
   assign bus.out_inst  = out_valid ? head_entry.inst : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a latency-randomised memory model, a
// program-order scoreboard of expected (addr, inst) pairs and a monitor that
// checks requests and decode-side deliveries.
module tb_fetch_unit;
   import riscv_pkg::*;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Memory contents: a fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return NOP;
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // ---------------- memory model ----------------
   typedef struct {
      logic [31:0] addr;
      longint      due;
   } pend_t;

   pend_t  pend[$];
   longint cyc       = 0;
   int     lat_min   = 1;
   int     lat_max   = 1;
   int     ready_pct = 100;

   initial begin
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         bus.imem_resp_valid = 1'b0;
         if (rst) begin
            pend.delete();
         end else begin
            if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
               bus.imem_resp_valid = 1'b1;
               bus.imem_resp_data  = mem_word(pend[0].addr);
               void'(pend.pop_front());
            end
            bus.imem_req_ready = ($urandom_range(99) < ready_pct);
         end
      end
   end

   // Record accepted requests (handshake happens at the coming posedge).
   always @(negedge clk) begin
      if (!rst && bus.imem_req_valid && bus.imem_req_ready)
         pend.push_back('{addr: bus.imem_req_addr,
                          due:  cyc + 1 + longint'($urandom_range(lat_max, lat_min))});
   end

   // ---------------- reference model / scoreboard ----------------
   fetch_entry_t exp_q[$];
   logic [31:0]  next_exp;
   logic [31:0]  exp_req_pc;
   int           deliv     = 0;
   int           req_count = 0;
   longint       deliv_cyc[$];
   logic         redir_prev = 1'b0;

   // Program order from the latest restart point is simply sequential words.
   function automatic void fill();
      repeat (4) begin
         exp_q.push_back('{addr: next_exp, inst: mem_word(next_exp)});
         next_exp = next_exp + 32'd4;
      end
   endfunction

   function automatic void restart_model(input logic [31:0] t);
      exp_q.delete();
      next_exp   = t & ~32'h3;
      exp_req_pc = t & ~32'h3;
   endfunction

   function automatic void set_redirect(input logic [31:0] t);
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = t;
      restart_model(t);
   endfunction

   // Monitor: every value seen here is what the next posedge will act on.
   initial begin
      fetch_entry_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            redir_prev = 1'b0;
         end else begin
            if (redir_prev)
               check("out_valid_after_redirect", 32'(bus.out_valid), 32'd0);
            if (bus.redirect_valid)
               check("req_valid_in_redirect", 32'(bus.imem_req_valid), 32'd0);
            if (bus.imem_req_valid && bus.imem_req_ready) begin
               check("req_addr", bus.imem_req_addr, exp_req_pc);
               exp_req_pc = exp_req_pc + 32'd4;
               req_count++;
            end
            if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
               if (exp_q.size() == 0) fill();
               e = exp_q.pop_front();
               check("out_addr", bus.out_addr, e.addr);
               check("out_inst", bus.out_inst, e.inst);
               deliv++;
               deliv_cyc.push_back(cyc);
            end
            redir_prev = bus.redirect_valid;
         end
      end
   end

   task automatic wait_deliv(input string name, input int n);
      int start = deliv;
      int k     = 0;
      while ((deliv - start) < n && k < 200) begin
         @(negedge clk);
         #1;
         k++;
      end
      check(name, ((deliv - start) >= n) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic redirect_once(input logic [31:0] t);
      @(posedge clk);
      #2;
      set_redirect(t);
      @(posedge clk);
      #2;
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int  start;
      bit  hit;
      logic [31:0] t;

      rst                 = 1'b1;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = '0;
      bus.out_ready       = 1'b1;
      restart_model(32'h0);

      // Reset state.
      #1;
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_addr", bus.out_addr, 32'd0);
      check("rst_out_inst", bus.out_inst, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("rst_misalign", 32'(bus.misalign_fault), 32'd0);
`endif
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;

      // Streaming start-up: 1-cycle memory, decode always ready.
      deliv_cyc.delete();
      wait_deliv("startup_deliveries", 6);
      check("startup_back_to_back", 32'(deliv_cyc[1] - deliv_cyc[0]), 32'd1);

      // Decode stalls: only DEPTH requests may be issued.
      @(posedge clk);
      #2;
      bus.out_ready = 1'b0;
      set_redirect(32'h0000_0040);
      @(posedge clk);
      #2;
      bus.redirect_valid = 1'b0;
      start = req_count;
      repeat (8) @(negedge clk);
      #1;
      check("stall_req_count", 32'(req_count - start), 32'(DEPTH));
      check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #2;
      bus.out_ready = 1'b1;
      wait_deliv("stall_resume", 6);

      // Redirect with requests in flight behind a slow memory.
      lat_min = 3;
      lat_max = 3;
      wait_deliv("slow_stream", 2);
      redirect_once(32'h0000_0100);
      wait_deliv("redirect_0x100", 4);

      // Redirect coinciding with a response arrival and a decode pop.
      lat_min = 1;
      lat_max = 1;
      hit     = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(posedge clk);
         #2;
         if (bus.imem_resp_valid && bus.out_valid && bus.out_ready) begin
            set_redirect(32'h0000_0200);
            hit = 1'b1;
         end
      end
      @(posedge clk);
      #2;
      bus.redirect_valid = 1'b0;
      check("same_cycle_redirect_seen", 32'(hit), 32'd1);
      wait_deliv("after_same_cycle_redirect", 4);

      // Misaligned redirect target.
`ifdef FETCH_MISALIGN_TRAP_EN
      redirect_once(32'h0000_0302);
      start = req_count;
      repeat (10) @(negedge clk);
      #1;
      check("misalign_fault", 32'(bus.misalign_fault), 32'd1);
      check("misalign_no_requests", 32'(req_count - start), 32'd0);
      check("misalign_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      restart_model(32'h0);
      #1;
      check("misalign_cleared", 32'(bus.misalign_fault), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      wait_deliv("after_fault_reset", 4);
`else
      redirect_once(32'h0000_0302);
      wait_deliv("misalign_truncated", 4);
`endif

      // PC wrap at the top of the address space.
      redirect_once(32'hFFFF_FFF8);
      wait_deliv("pc_wrap", 4);

      // Random traffic: random memory stalls/latency, decode back-pressure, redirects.
      lat_min   = 1;
      lat_max   = 4;
      ready_pct = 70;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #2;
         bus.out_ready      = ($urandom_range(99) < 80);
         bus.redirect_valid = 1'b0;
         if ($urandom_range(99) < 6) begin
            t = $urandom();
`ifdef FETCH_MISALIGN_TRAP_EN
            t = t & ~32'h2;
`endif
            set_redirect(t);
         end
      end
      @(posedge clk);
      #2;
      bus.redirect_valid = 1'b0;
      bus.out_ready      = 1'b1;
      ready_pct          = 100;
      wait_deliv("random_drain", 4);

      // Asynchronous reset in the middle of traffic.
      @(posedge clk);
      #2;
      rst = 1'b1;
      restart_model(32'h0);
      #1;
      check("midrst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_out_addr", bus.out_addr, 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      wait_deliv("after_mid_reset", 4);

      repeat (4) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
